// File: rtl/compressor_pkg.sv
// Shared definitions for the compressor back end: tag encoding, packer FSM states and the
// tag-to-byte-length mapping.
package compressor_pkg;

  localparam logic [1:0] TAG_ZERO = 2'd0;
  localparam logic [1:0] TAG_B1   = 2'd1;
  localparam logic [1:0] TAG_B2   = 2'd2;
  localparam logic [1:0] TAG_RAW  = 2'd3;

  typedef enum logic {
    StRun,
    StFlush
  } pack_state_e;

  function automatic int unsigned tag2len(input logic [1:0] tag, input int unsigned lane_bytes);
    int unsigned len;
    case (tag)
      TAG_ZERO: len = 0;
      TAG_B1:   len = 1;
      TAG_B2:   len = 2;
      default:  len = lane_bytes;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lane_merge_tree.sv
// Combinational pairwise merge of per-lane (payload, length) pairs into one dense,
// MSB-aligned byte string; the highest lane lands first.
module lane_merge_tree
  import compressor_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 2,
  localparam int unsigned LANE_BYTES = DATA_WIDTH / 8,
  localparam int unsigned OUT_BYTES  = NUM_LANES * LANE_BYTES,
  localparam int unsigned OUT_BITS   = OUT_BYTES * 8,
  localparam int unsigned LEN_W      = $clog2(OUT_BYTES + 1)
) (
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]  lane_tag,
  output logic [OUT_BITS-1:0]             merged_data,
  output logic [LEN_W-1:0]                merged_len
);

  localparam int unsigned LEVELS = $clog2(NUM_LANES);

  logic [OUT_BITS-1:0] node_data [NUM_LANES];
  logic [LEN_W-1:0]    node_len  [NUM_LANES];
  logic [LEN_W-1:0]    pad;

  always_comb begin
    pad = '0;
    // Leaves: keep the low len bytes of each lane, moved to the top of a zeroed node.
    for (int i = 0; i < NUM_LANES; i++) begin
      node_len[i]  = LEN_W'(tag2len(lane_tag[i*TAG_WIDTH +: 2], LANE_BYTES));
      pad          = LEN_W'(LANE_BYTES) - node_len[i];
      node_data[i] = '0;
      node_data[i][OUT_BITS-1 -: DATA_WIDTH] =
        lane_data[i*DATA_WIDTH +: DATA_WIDTH] << {pad, 3'b000};
    end
    // Level l merges node i+2^l (higher lanes, earlier in stream) with node i in place.
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < (NUM_LANES >> (l + 1)); k++) begin
        node_data[k*(2<<l)] = node_data[k*(2<<l) + (1<<l)] |
                              (node_data[k*(2<<l)] >> {node_len[k*(2<<l) + (1<<l)], 3'b000});
        node_len[k*(2<<l)]  = node_len[k*(2<<l)] + node_len[k*(2<<l) + (1<<l)];
      end
    end
    merged_data = node_data[0];
    merged_len  = node_len[0];
  end

endmodule

// File: rtl/compressor_stream_packer.sv
// Packs variable-length lane payloads into fixed-width output beats, with end-of-stream
// flush producing a partial, zero-padded final beat.
module compressor_stream_packer
  import compressor_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 2,
  localparam int unsigned LANE_BYTES = DATA_WIDTH / 8,
  localparam int unsigned OUT_BYTES  = NUM_LANES * LANE_BYTES,
  localparam int unsigned CNT_W      = $clog2(2 * OUT_BYTES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            inLast,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] cprDataIn,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]  tagIn,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [OUT_BYTES*8-1:0]          dataOut,
  output logic [CNT_W-1:0]                outBytes,
  output logic                            outLast,
  output logic                            tagValid,
  output logic [NUM_LANES*TAG_WIDTH-1:0]  tagOut
);

  localparam int unsigned OUT_BITS = OUT_BYTES * 8;
  localparam int unsigned ACC_BITS = 2 * OUT_BITS;
  localparam int unsigned LEN_W    = $clog2(OUT_BYTES + 1);
  localparam logic [CNT_W-1:0] OB_CNT = CNT_W'(OUT_BYTES);

  logic [OUT_BITS-1:0] blk_data;
  logic [LEN_W-1:0]    blk_len;

  lane_merge_tree #(
    .NUM_LANES (NUM_LANES),
    .DATA_WIDTH(DATA_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_merge (
    .lane_data  (cprDataIn),
    .lane_tag   (tagIn),
    .merged_data(blk_data),
    .merged_len (blk_len)
  );

  pack_state_e                    state_q, state_d;
  logic [ACC_BITS-1:0]            acc_q, acc_d, acc_base;
  logic [CNT_W-1:0]               count_q, count_d, cnt_base;
  logic                           ready_en_q;
  logic                           tag_valid_q;
  logic [NUM_LANES*TAG_WIDTH-1:0] tag_out_q;

  logic flush_pend, out_valid, out_last, out_fire, in_ready, in_fire;

  assign flush_pend = (state_q == StFlush);
  assign out_valid  = (count_q >= OB_CNT) | flush_pend;
  assign out_last   = flush_pend & (count_q <= OB_CNT);
  assign out_fire   = out_valid & outReady;
  // ready_en_q holds inReady low for the first cycle after reset release.
  assign in_ready   = ready_en_q & ~flush_pend & ((count_q < OB_CNT) | out_fire);
  assign in_fire    = inValid & in_ready;

  always_comb begin
    state_d  = state_q;
    acc_base = acc_q;
    cnt_base = count_q;
    if (out_fire) begin
      if (out_last) begin
        acc_base = '0;
        cnt_base = '0;
        state_d  = StRun;
      end else begin
        acc_base = acc_q << OUT_BITS;
        cnt_base = count_q - OB_CNT;
      end
    end
    acc_d   = acc_base;
    count_d = cnt_base;
    // Bytes past count are always zero, so appending is a shifted OR.
    if (in_fire) begin
      acc_d   = acc_base | ({blk_data, {OUT_BITS{1'b0}}} >> {cnt_base, 3'b000});
      count_d = cnt_base + CNT_W'(blk_len);
      if (inLast) begin
        state_d = StFlush;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      acc_q       <= '0;
      count_q     <= '0;
      ready_en_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ready_en_q  <= 1'b1;
      tag_valid_q <= in_fire;
      if (in_fire) begin
        tag_out_q <= tagIn;
      end
    end
  end

  assign inReady  = in_ready;
  assign outValid = out_valid;
  assign outLast  = out_last;
  assign outBytes = out_valid ? (out_last ? count_q : OB_CNT) : '0;
  assign dataOut  = acc_q[ACC_BITS-1 -: OUT_BITS];
  assign tagValid = tag_valid_q;
  assign tagOut   = tag_out_q;

endmodule
